// File: rtl/serial_frame_sequencer_if.sv
// serial_frame_sequencer_if: pixel-source and UART-sink handshake bundle
interface serial_frame_sequencer_if;
  logic [7:0] pix_char;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  modport master (input pix_char, pix_valid, tx_ready, output pix_ready, tx_data, tx_valid);
  modport slave (output pix_char, pix_valid, tx_ready, input pix_ready, tx_data, tx_valid);
endinterface

// File: rtl/serial_frame_sequencer.sv
// serial_frame_sequencer: streams ESC[H, COLS chars + CR LF per row, for ROWS rows, to a UART
module serial_frame_sequencer #(
  parameter int COLS = 80,
  parameter int ROWS = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  serial_frame_sequencer_if.master bus,
  output logic frame_start,
  output logic frame_done,
  output logic busy
);
  localparam int CW = $clog2(COLS);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  typedef enum logic [2:0] {IDLE, HOME, ROW, CR, LF, DONE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [1:0]    seq_q, seq_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          avail, load, last_col, last_row;
  logic [7:0]    src;
  // next state, counters and output byte register; a load needs ena, a free slot and a source byte
  always_comb begin
    avail = state_q inside {HOME, CR, LF} || (state_q == ROW && bus.pix_valid);
    load = ena && (!tx_valid_q || bus.tx_ready) && avail;
    last_col = col_q == CW'(COLS - 1);
    last_row = row_q == RW'(ROWS - 1);
    src = state_q == ROW ? bus.pix_char :
          state_q == CR  ? 8'h0D :
          state_q == LF  ? 8'h0A :
          seq_q == 2'd0  ? 8'h1B :
          seq_q == 2'd1  ? 8'h5B : 8'h48;
    state_d = state_q;
    col_d = col_q;
    row_d = row_q;
    seq_d = seq_q;
    case (state_q)
      IDLE: state_d = ena ? HOME : IDLE;
      HOME: if (load) begin
        seq_d = seq_q == 2'd2 ? 2'd0 : seq_q + 2'd1;
        state_d = seq_q == 2'd2 ? ROW : HOME;
        col_d = '0;
        row_d = '0;
      end
      ROW: if (load) begin
        col_d = last_col ? '0 : col_q + CW'(1);
        state_d = last_col ? CR : ROW;
      end
      CR: if (load) state_d = LF;
      LF: if (load) begin
        row_d = last_row ? '0 : row_q + RW'(1);
        col_d = '0;
        state_d = last_row ? DONE : ROW;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    tx_data_d = load ? src : tx_data_q;
    tx_valid_d = load || (tx_valid_q && !bus.tx_ready);
  end
  // state and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q <= '0;
      row_q <= '0;
      seq_q <= '0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      seq_q <= seq_d;
    end
  end
  // output byte register, kept apart from the sequencing state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_q <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      tx_data_q <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end
  assign bus.pix_ready = state_q == ROW && load;
  assign bus.tx_data = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign frame_start = rst_n && state_q == IDLE && ena;
  assign frame_done = state_q == DONE;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_serial_frame_sequencer.sv
// tb_serial_frame_sequencer: randomized and directed checks against a frame-layout model
module tb_serial_frame_sequencer;
  localparam int C = 4, R = 2, TOT = 3 + R * (C + 2);
  localparam int BC = 80, BR = 24, BTOT = 3 + BR * (BC + 2);
  logic clk = 1'b0, rst_n = 1'b0, ena_s = 1'b0, ena_l = 1'b0;
  logic fs_s, fd_s, busy_s, fs_l, fd_l, busy_l;
  int checks = 0, errors = 0;
  int ps = 0, cidx = 0, starts = 0, dones = 0, s0 = 0, d0 = 0, pl = 0, bstarts = 0;
  int mode_tx = 0, mode_pix = 0;
  bit rnd_char = 0, rnd_ena = 0, done_seen = 0, done_l = 0, hold = 0;
  logic [7:0] hold_d, x_s;
  logic [8:0] e_s, e_l;
  logic [7:0] cq[$], got[$];
  logic [7:0] exp37 [15] = '{8'h1B, 8'h5B, 8'h48, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A,
                             8'h45, 8'h46, 8'h47, 8'h48, 8'h0D, 8'h0A};
  serial_frame_sequencer_if bs();
  serial_frame_sequencer_if bl();
  serial_frame_sequencer #(.COLS(C), .ROWS(R)) dut_s (
    .clk(clk), .rst_n(rst_n), .ena(ena_s), .bus(bs),
    .frame_start(fs_s), .frame_done(fd_s), .busy(busy_s));
  serial_frame_sequencer #(.COLS(BC), .ROWS(BR)) dut_l (
    .clk(clk), .rst_n(rst_n), .ena(ena_l), .bus(bl),
    .frame_start(fs_l), .frame_done(fd_l), .busy(busy_l));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  // {is_char, byte} expected at position p of a frame with the given row width
  function automatic logic [8:0] ctl(input int p, input int cols);
    int q;
    if (p == 0) return 9'h01B;
    if (p == 1) return 9'h05B;
    if (p == 2) return 9'h048;
    q = (p - 3) % (cols + 2);
    return q < cols ? 9'h100 : q == cols ? 9'h00D : 9'h00A;
  endfunction
  always @(negedge clk) begin
    if (!rst_n) begin
      ps = 0;
      cidx = 0;
      hold = 0;
      cq.delete();
    end else begin
      if (hold) begin
        chk("hold_valid", bs.tx_valid, 1);
        chk("hold_data", bs.tx_data, hold_d);
      end
      if (fs_s) begin
        starts++;
        cidx = 0;
      end
      if (bs.pix_ready) begin
        chk("pix_ready_cond", {ena_s, bs.pix_valid, !bs.tx_valid || bs.tx_ready}, 3'b111);
        cq.push_back(bs.pix_char);
        cidx++;
      end
      if (fd_s) begin
        dones++;
        done_seen = 1;
        chk("done_pos", ps % TOT, TOT - 1);
        chk("done_last", {bs.tx_valid, bs.tx_data}, 9'h10A);
      end
      if (bs.tx_valid && bs.tx_ready) begin
        e_s = ctl(ps % TOT, C);
        x_s = 8'h00;
        if (e_s[8]) begin
          chk("char_avail", cq.size() > 0, 1);
          if (cq.size() > 0) x_s = cq.pop_front();
        end
        chk("tx_byte", bs.tx_data, e_s[8] ? x_s : e_s[7:0]);
        got.push_back(bs.tx_data);
        ps++;
      end
      hold = bs.tx_valid && !bs.tx_ready;
      hold_d = bs.tx_data;
    end
  end
  always @(negedge clk) begin
    if (rst_n && fs_l) bstarts++;
    if (rst_n && bl.tx_valid && bl.tx_ready) begin
      e_l = ctl(pl, BC);
      chk("big_byte", bl.tx_data, e_l[8] ? 8'h2A : e_l[7:0]);
      pl++;
    end
    if (rst_n && fd_l) begin
      done_l = 1;
      chk("big_count", pl, BTOT);
      chk("big_last", bl.tx_data, 8'h0A);
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
    bs.tx_ready = mode_tx == 0 ? 1'b1 : mode_tx == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    bs.pix_valid = mode_pix == 0 ? 1'b1 : mode_pix == 1 ? 1'($urandom_range(0, 1)) : !bs.pix_valid;
    bs.pix_char = rnd_char ? 8'($urandom) : 8'(8'h41 + cidx % 26);
    if (rnd_ena) ena_s = $urandom_range(0, 3) != 0;
  endtask
  task automatic start_frame();
    s0 = starts;
    d0 = dones;
    got.delete();
    done_seen = 0;
    ena_s = 1;
  endtask
  task automatic finish_frame();
    int n = 0;
    while (!done_seen && n < 3000) begin
      step();
      n++;
    end
    chk("frame_timeout", done_seen, 1);
    rnd_ena = 0;
    ena_s = 0;
    mode_tx = 0;
    n = 0;
    while (bs.tx_valid && n < 10) begin
      step();
      n++;
    end
    chk("frame_starts", starts - s0, 1);
    chk("frame_dones", dones - d0, 1);
    chk("frame_bytes", got.size(), TOT);
  endtask
  initial begin
    int n;
    bs.pix_char = 8'h00;
    bs.pix_valid = 1'b0;
    bs.tx_ready = 1'b0;
    bl.pix_char = 8'h2A;
    bl.pix_valid = 1'b1;
    bl.tx_ready = 1'b1;
    ena_s = 1;
    #2;
    chk("rst_valid", bs.tx_valid, 0);
    chk("rst_data", bs.tx_data, 0);
    chk("rst_pix_ready", bs.pix_ready, 0);
    chk("rst_start", fs_s, 0);
    chk("rst_done", fd_s, 0);
    chk("rst_busy", busy_s, 0);
    ena_s = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    step();
    chk("idle_busy", busy_s, 0);
    chk("idle_valid", bs.tx_valid, 0);
    start_frame();
    finish_frame();
    for (int i = 0; i < 15; i++) chk("stream_ref", got[i], exp37[i]);
    start_frame();
    n = 0;
    while (!(bs.tx_valid && bs.tx_data == 8'h5B) && n < 20) begin
      step();
      n++;
    end
    chk("see_5b", bs.tx_data, 8'h5B);
    mode_tx = 2;
    bs.tx_ready = 0;
    repeat (5) begin
      step();
      chk("stall_data", bs.tx_data, 8'h5B);
      chk("stall_valid", bs.tx_valid, 1);
    end
    mode_tx = 0;
    bs.tx_ready = 1;
    step();
    chk("after_stall", bs.tx_data, 8'h48);
    finish_frame();
    mode_pix = 2;
    start_frame();
    finish_frame();
    mode_pix = 0;
    start_frame();
    n = 0;
    while (!(bs.tx_valid && bs.tx_data == 8'h42) && n < 20) begin
      step();
      n++;
    end
    chk("see_42", bs.tx_data, 8'h42);
    mode_tx = 2;
    bs.tx_ready = 0;
    ena_s = 0;
    repeat (3) begin
      step();
      chk("pause_hold_data", bs.tx_data, 8'h42);
      chk("pause_hold_valid", bs.tx_valid, 1);
    end
    mode_tx = 0;
    bs.tx_ready = 1;
    repeat (3) step();
    chk("paused_valid", bs.tx_valid, 0);
    chk("paused_busy", busy_s, 1);
    chk("paused_pix_ready", bs.pix_ready, 0);
    ena_s = 1;
    step();
    chk("resume_char", {bs.tx_valid, bs.tx_data}, 9'h143);
    finish_frame();
    start_frame();
    n = 0;
    while (ps % TOT < 10 && n < 40) begin
      step();
      n++;
    end
    chk("reach_row1", ps % TOT >= 10, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", bs.tx_valid, 0);
    chk("arst_data", bs.tx_data, 0);
    chk("arst_pix_ready", bs.pix_ready, 0);
    chk("arst_start", fs_s, 0);
    chk("arst_done", fd_s, 0);
    chk("arst_busy", busy_s, 0);
    @(posedge clk);
    #1 rst_n = 1;
    start_frame();
    finish_frame();
    chk("rst_first", got[0], 8'h1B);
    for (int k = 0; k < 6; k++) begin
      mode_tx = 1;
      mode_pix = 1;
      rnd_char = 1;
      rnd_ena = 1;
      start_frame();
      finish_frame();
    end
    mode_pix = 0;
    rnd_char = 0;
    ena_l = 1;
    n = 0;
    while (!done_l && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    ena_l = 0;
    chk("big_timeout", done_l, 1);
    chk("big_starts", bstarts, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("big_idle", busy_l, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
